arbitrated_lookup_table: RTL and testbench
==========================================

ARBITRATED_LOOKUP_TABLE -- requirements
Module: arbitrated_lookup_table

Interface
REQ-001 SHALL have parameter W, default 2: number of write requesters.
REQ-002 SHALL have parameter R, default 2: number of read requesters.
REQ-003 SHALL have parameter D, default 16: table depth, entries.
REQ-004 SHALL have parameter WIDTH, default 32: entry data width.
REQ-005 SHALL derive LOG_D, LOG_W and LOG_R as clog2 of D, W and R, with a minimum of 1.
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port rstn, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port wrVld_i, input, W: per-writer request valid.
REQ-009 SHALL have port wrRdy_o, output, W: per-writer grant, one-hot or zero.
REQ-010 SHALL have port wrId_i[W], input, LOG_D each: target entry index.
REQ-011 SHALL have port wrData_i[W], input, WIDTH each: write data.
REQ-012 SHALL have port wrInv_i, input, W: 1 = invalidate the entry instead of writing it.
REQ-013 SHALL have port rdVld_i, input, R: per-reader lookup valid.
REQ-014 SHALL have port rdRdy_o, output, R: per-reader grant, one-hot or zero.
REQ-015 SHALL have port rdId_i[R], input, LOG_D each: lookup index.
REQ-016 SHALL have port flush_i, input, 1: invalidate all entries.
REQ-017 SHALL have port rspVld_o, output, 1: lookup response valid.
REQ-018 SHALL have port rspIdx_o, output, LOG_R: index of the reader that owns the response.
REQ-019 SHALL have port rspHit_o, output, 1: entry-valid bit of the looked-up entry.
REQ-020 SHALL have port rspData_o, output, WIDTH: looked-up entry data.
REQ-021 SHALL have port count_o, output, LOG_D+1: number of valid entries.

Function
REQ-022 SHALL grant at most one writer and one reader per cycle, each through an independent round-robin arbiter.
REQ-023 SHALL advance an arbiter's priority pointer only in cycles where it grants, moving it to the slot after the winner.
REQ-024 SHALL transfer a request only when valid and ready are both high; requesters hold valid, id and data stable until ready.
REQ-025 SHALL, on a write grant with wrInv_i=0, store data and set the entry-valid bit at the next edge.
REQ-026 SHALL, on a write grant with wrInv_i=1, clear the entry-valid bit and leave the data unchanged.
REQ-027 SHALL present the read response one cycle after the read grant: rspVld_o=1, with rspIdx_o, rspHit_o and rspData_o registered.
REQ-028 SHALL hold rspVld_o=0 in cycles that follow no read grant; response fields then keep their previous values.
REQ-029 SHALL give the read response the granted write's effect when a read and a write to the same index are granted in the same cycle (write-first forwarding).
REQ-030 SHALL update count_o as follows: write to an invalid entry +1; invalidate of a valid entry -1; write to a valid entry or invalidate of an invalid entry 0.
REQ-031 SHALL, while flush_i=1, force wrRdy_o and rdRdy_o to 0, clear all valid bits at the edge and set count_o to 0; data is retained.
REQ-032 SHALL keep count_o saturated within 0..D and never wrap.
REQ-033 SHALL have no backpressure on the response; consumers accept rspVld_o unconditionally.

Reset
REQ-034 SHALL, on rstn low, clear immediately: all valid bits, all data, count_o, rspVld_o, rspIdx_o, rspHit_o and rspData_o to 0, with both arbiter pointers set to requester 0 highest priority.
REQ-035 SHALL, on reset asserted mid-transaction, drop any granted-but-unresponded read with no response issued after release.

Structure
REQ-036 SHALL place in shared package lookup_table_pkg: the response struct typedef (vld, idx, hit, data) and the default parameter constants.
REQ-037 SHALL instantiate the existing rr_arbiter sub-module twice (write and read); no other sub-modules.
REQ-038 SHALL hold the table in a flop array with a separate D-bit valid vector.

Verification
REQ-039 SHALL cover: writers 0 and 1 both valid for 4 cycles -> grants alternate 0,1,0,1 after reset; count_o=2 if ids 3 and 5 are distinct.
REQ-040 SHALL cover: write id 7 = 0xDEADBEEF, then a read of id 7 granted next cycle -> one cycle later rspVld_o=1, rspHit_o=1, rspData_o=0xDEADBEEF.
REQ-041 SHALL cover: a same-cycle write of id 4 = 0x55 and read of id 4 -> the response shows hit=1, data=0x55; an invalidate of id 4 in the same pattern -> hit=0.
REQ-042 SHALL cover: 3 entries valid, then flush_i=1 while all requesters are valid -> no grants that cycle, count_o=0 next cycle, a later read returns hit=0 with the old data.
REQ-043 SHALL cover: writing all D entries, then rewriting id 0 -> count_o stays at D; invalidating an already-invalid entry leaves count_o unchanged.
REQ-044 SHALL cover: rstn asserted the cycle after a read grant -> no rspVld_o pulse and all outputs 0 through and after release.

Source files
------------

// File: rtl/lookup_table_pkg.sv
// Shared definitions for the arbitrated lookup table.
//   - Default parameter constants for the table and its requesters.
//   - clog2_min1(): ceil(log2(n)) with a floor of 1, so that index fields
//     always have at least one bit.
//   - rsp_t: lookup response record (vld, idx, hit, data), sized for the
//     default configuration.
package lookup_table_pkg;

  localparam int DEF_W     = 2;
  localparam int DEF_R     = 2;
  localparam int DEF_D     = 16;
  localparam int DEF_WIDTH = 32;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_LOG_R = clog2_min1(DEF_R);

  typedef struct packed {
    logic                 vld;
    logic [DEF_LOG_R-1:0] idx;
    logic                 hit;
    logic [DEF_WIDTH-1:0] data;
  } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//   clk, rstn : clock, asynchronous active-low reset
//   en_i      : when low no grant is issued and the pointer holds
//   req_i     : per-requester request
//   gnt_o     : one-hot grant (or zero), combinational from req_i
//   idx_o     : index of the granted requester (0 when nothing granted)
// The priority pointer names the requester with highest priority. It moves
// to the slot after the winner only in cycles that grant; reset points it at
// requester 0.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int LOG_N = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     gnt_o,
  output logic [LOG_N-1:0] idx_o
);

  logic [LOG_N-1:0] ptr_q, ptr_d;
  logic             found;
  logic [LOG_N-1:0] k;
  int               s;

  // Scan requesters starting at the pointer, wrapping modulo N; the first
  // requester found wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = '0;
    s     = 0;
    for (int i = 0; i < N; i++) begin
      s = int'(ptr_q) + i;
      if (s >= N) s = s - N;
      k = LOG_N'(s);
      if (en_i && !found && req_i[k]) begin
        gnt_o[k] = 1'b1;
        idx_o    = k;
        found    = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (int'(idx_o) == N - 1) ? '0 : idx_o + LOG_N'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/arbitrated_lookup_table.sv
// Lookup table shared by W writers and R readers.
//   clk, rstn          : clock, asynchronous active-low reset
//   wrVld_i/wrRdy_o    : writer request / grant (grant one-hot or zero)
//   wrId_i, wrData_i   : writer target index and data
//   wrInv_i            : 1 = clear the entry-valid bit instead of writing
//   rdVld_i/rdRdy_o    : reader request / grant (grant one-hot or zero)
//   rdId_i             : reader lookup index
//   flush_i            : clear every valid bit; blocks all grants
//   rspVld_o           : one-cycle pulse, lookup result registered
//   rspIdx_o           : reader that owns the response
//   rspHit_o/rspData_o : entry-valid bit and data of the looked-up entry
//   count_o            : number of valid entries (0..D)
//
// Handshake: a request transfers in a cycle where its valid and ready are
// both high. A requester keeps valid, id and data stable until it sees ready;
// ready depends combinationally on valid. The response has no backpressure.
module arbitrated_lookup_table
  import lookup_table_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int R     = DEF_R,
  parameter int D     = DEF_D,
  parameter int WIDTH = DEF_WIDTH,
  localparam int LOG_D = clog2_min1(D),
  localparam int LOG_W = clog2_min1(W),
  localparam int LOG_R = clog2_min1(R)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [W-1:0]     wrVld_i,
  output logic [W-1:0]     wrRdy_o,
  input  logic [LOG_D-1:0] wrId_i   [W],
  input  logic [WIDTH-1:0] wrData_i [W],
  input  logic [W-1:0]     wrInv_i,
  input  logic [R-1:0]     rdVld_i,
  output logic [R-1:0]     rdRdy_o,
  input  logic [LOG_D-1:0] rdId_i   [R],
  input  logic             flush_i,
  output logic             rspVld_o,
  output logic [LOG_R-1:0] rspIdx_o,
  output logic             rspHit_o,
  output logic [WIDTH-1:0] rspData_o,
  output logic [LOG_D:0]   count_o
);

  // Same field layout as lookup_table_pkg::rsp_t, sized by this instance.
  typedef struct packed {
    logic             vld;
    logic [LOG_R-1:0] idx;
    logic             hit;
    logic [WIDTH-1:0] data;
  } rsp_reg_t;

  localparam logic [LOG_D:0] D_CNT   = (LOG_D + 1)'(D);
  localparam logic [LOG_D:0] CNT_ONE = (LOG_D + 1)'(1);

  logic [W-1:0]     wr_gnt;
  logic [LOG_W-1:0] wr_sel;
  logic [R-1:0]     rd_gnt;
  logic [LOG_R-1:0] rd_sel;

  logic             wr_fire, rd_fire, wr_inv;
  logic [LOG_D-1:0] wr_id, rd_id;
  logic [WIDTH-1:0] wr_data;

  logic [WIDTH-1:0] data_q [D];
  logic [WIDTH-1:0] data_d [D];
  logic [D-1:0]     valid_q, valid_d;
  logic [LOG_D:0]   count_q, count_d;
  rsp_reg_t         rsp_q, rsp_d;

  // Flush blocks both arbiters, so no grant (and no pointer move) happens
  // in a flush cycle.
  rr_arbiter #(.N(W), .LOG_N(LOG_W)) u_wr_arb (
    .clk   (clk),
    .rstn  (rstn),
    .en_i  (!flush_i),
    .req_i (wrVld_i),
    .gnt_o (wr_gnt),
    .idx_o (wr_sel)
  );

  rr_arbiter #(.N(R), .LOG_N(LOG_R)) u_rd_arb (
    .clk   (clk),
    .rstn  (rstn),
    .en_i  (!flush_i),
    .req_i (rdVld_i),
    .gnt_o (rd_gnt),
    .idx_o (rd_sel)
  );

  always_comb begin
    wr_fire = |wr_gnt;
    rd_fire = |rd_gnt;
    wr_id   = wrId_i[wr_sel];
    wr_data = wrData_i[wr_sel];
    wr_inv  = wrInv_i[wr_sel];
    rd_id   = rdId_i[rd_sel];
  end

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    count_d   = count_q;
    rsp_d     = rsp_q;
    rsp_d.vld = 1'b0;

    if (flush_i) begin
      valid_d = '0;
      count_d = '0;
    end else if (wr_fire) begin
      if (wr_inv) begin
        valid_d[wr_id] = 1'b0;
        if (valid_q[wr_id] && (count_q != '0)) count_d = count_q - CNT_ONE;
      end else begin
        data_d[wr_id]  = wr_data;
        valid_d[wr_id] = 1'b1;
        if (!valid_q[wr_id] && (count_q < D_CNT)) count_d = count_q + CNT_ONE;
      end
    end

    // A write granted in the same cycle to the same index is visible to the
    // read (write-first). An invalidate leaves the stored data untouched.
    if (rd_fire) begin
      rsp_d.vld = 1'b1;
      rsp_d.idx = rd_sel;
      if (wr_fire && (wr_id == rd_id)) begin
        rsp_d.hit  = !wr_inv;
        rsp_d.data = wr_inv ? data_q[rd_id] : wr_data;
      end else begin
        rsp_d.hit  = valid_q[rd_id];
        rsp_d.data = data_q[rd_id];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < D; i++) data_q[i] <= '0;
      valid_q <= '0;
      count_q <= '0;
      rsp_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
      rsp_q   <= rsp_d;
    end
  end

  assign wrRdy_o   = wr_gnt;
  assign rdRdy_o   = rd_gnt;
  assign rspVld_o  = rsp_q.vld;
  assign rspIdx_o  = rsp_q.idx;
  assign rspHit_o  = rsp_q.hit;
  assign rspData_o = rsp_q.data;
  assign count_o   = count_q;

endmodule

// File: tb/tb_arbitrated_lookup_table.sv
module tb_arbitrated_lookup_table;

  localparam int EW = 1 + 1 + 32;

  logic        clk;
  logic        rstn;
  logic [1:0]  wrVld;
  logic [1:0]  wrRdy_o;
  logic [3:0]  wrId   [2];
  logic [31:0] wrData [2];
  logic [1:0]  wrInv;
  logic [1:0]  rdVld;
  logic [1:0]  rdRdy_o;
  logic [3:0]  rdId   [2];
  logic        flush;
  logic        rspVld_o;
  logic [0:0]  rspIdx_o;
  logic        rspHit_o;
  logic [31:0] rspData_o;
  logic [4:0]  count_o;

  logic [EW-1:0] exp_q[$];

  logic [31:0] mdl_data [16];
  logic        mdl_vld  [16];
  int          mdl_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  arbitrated_lookup_table dut (
    .clk       (clk),
    .rstn      (rstn),
    .wrVld_i   (wrVld),
    .wrRdy_o   (wrRdy_o),
    .wrId_i    (wrId),
    .wrData_i  (wrData),
    .wrInv_i   (wrInv),
    .rdVld_i   (rdVld),
    .rdRdy_o   (rdRdy_o),
    .rdId_i    (rdId),
    .flush_i   (flush),
    .rspVld_o  (rspVld_o),
    .rspIdx_o  (rspIdx_o),
    .rspHit_o  (rspHit_o),
    .rspData_o (rspData_o),
    .count_o   (count_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every expected response must appear exactly one cycle after
  // its grant; any response pulse with nothing expected is an error.
  always @(negedge clk) begin
    if (rstn) begin
      if (rspVld_o) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rspVld_o), 64'd0);
        end else begin
          check("rsp_fields", 64'({rspIdx_o, rspHit_o, rspData_o}), 64'(exp_q.pop_front()));
        end
      end else if (exp_q.size() != 0) begin
        check("rsp_missing", 64'(rspVld_o), 64'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    wrVld = '0;
    rdVld = '0;
    wrInv = '0;
    flush = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mdl_data[i] = '0;
      mdl_vld[i]  = 1'b0;
    end
    mdl_cnt = 0;
  endtask

  // Called at posedge+1 with inputs already driven. Checks grants against
  // the bench's expected one-hot values, advances the model, queues the
  // expected response, and returns at the next posedge+1.
  task automatic run_cycle(input logic [1:0] exp_wr, input logic [1:0] exp_rd, input string tag);
    logic [EW-1:0] e;
    logic          pend;
    int            wi, ri, id;
    #1;
    check({tag, "_wrRdy"}, 64'(wrRdy_o), 64'(exp_wr));
    check({tag, "_rdRdy"}, 64'(rdRdy_o), 64'(exp_rd));
    pend = 1'b0;
    e    = '0;
    if (flush) begin
      for (int i = 0; i < 16; i++) mdl_vld[i] = 1'b0;
      mdl_cnt = 0;
    end
    if (exp_wr != 2'b00) begin
      wi = exp_wr[1] ? 1 : 0;
      id = int'(wrId[wi]);
      if (wrInv[wi]) begin
        if (mdl_vld[id]) mdl_cnt--;
        mdl_vld[id] = 1'b0;
      end else begin
        if (!mdl_vld[id]) mdl_cnt++;
        mdl_vld[id]  = 1'b1;
        mdl_data[id] = wrData[wi];
      end
    end
    if (exp_rd != 2'b00) begin
      ri   = exp_rd[1] ? 1 : 0;
      id   = int'(rdId[ri]);
      e    = {1'(ri), mdl_vld[id], mdl_data[id]};
      pend = 1'b1;
    end
    @(posedge clk);
    #1;
    if (pend) exp_q.push_back(e);
    check({tag, "_count"}, 64'(count_o), 64'(mdl_cnt));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int wi, ri;
    logic [1:0] ew, er;

    rstn = 1'b0;
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      wrId[i] = '0; wrData[i] = '0; rdId[i] = '0;
    end
    model_reset();

    #3;
    check("reset_count",  64'(count_o),   64'd0);
    check("reset_rspVld", 64'(rspVld_o),  64'd0);
    check("reset_rspIdx", 64'(rspIdx_o),  64'd0);
    check("reset_rspHit", 64'(rspHit_o),  64'd0);
    check("reset_rspDat", 64'(rspData_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Two writers contending: grants alternate 0,1,0,1.
    wrVld = 2'b11;
    wrId[0] = 4'd3; wrData[0] = 32'h11;
    wrId[1] = 4'd5; wrData[1] = 32'h22;
    run_cycle(2'b01, 2'b00, "rr_c1");
    run_cycle(2'b10, 2'b00, "rr_c2");
    run_cycle(2'b01, 2'b00, "rr_c3");
    run_cycle(2'b10, 2'b00, "rr_c4");
    check("rr_count2", 64'(count_o), 64'd2);
    idle_inputs();

    // Write then read of id 7.
    wrVld = 2'b01; wrId[0] = 4'd7; wrData[0] = 32'hDEADBEEF;
    run_cycle(2'b01, 2'b00, "wr7");
    wrVld = 2'b00;
    rdVld = 2'b01; rdId[0] = 4'd7;
    run_cycle(2'b00, 2'b01, "rd7");
    check("rd7_vld",  64'(rspVld_o),  64'd1);
    check("rd7_hit",  64'(rspHit_o),  64'd1);
    check("rd7_data", 64'(rspData_o), 64'hDEADBEEF);
    rdVld = 2'b00;
    run_cycle(2'b00, 2'b00, "idle1");
    check("idle_vld0",  64'(rspVld_o),  64'd0);
    check("idle_hold",  64'(rspData_o), 64'hDEADBEEF);

    // Two readers contending; reader pointer sits at 1 after reader 0 won.
    rdVld = 2'b11; rdId[0] = 4'd3; rdId[1] = 4'd5;
    run_cycle(2'b00, 2'b10, "rdrr_c1");
    check("rdrr_idx1", 64'(rspIdx_o), 64'd1);
    run_cycle(2'b00, 2'b01, "rdrr_c2");
    check("rdrr_idx0", 64'(rspIdx_o), 64'd0);
    rdVld = 2'b00;

    // Same-cycle write and read of id 4: write-first.
    wrVld = 2'b10; wrId[1] = 4'd4; wrData[1] = 32'h55; wrInv = 2'b00;
    rdVld = 2'b10; rdId[1] = 4'd4;
    run_cycle(2'b10, 2'b10, "fwd_wr");
    check("fwd_wr_hit",  64'(rspHit_o),  64'd1);
    check("fwd_wr_data", 64'(rspData_o), 64'h55);
    wrVld = 2'b01; wrId[0] = 4'd4; wrData[0] = 32'h99; wrInv = 2'b01;
    rdVld = 2'b01; rdId[0] = 4'd4;
    run_cycle(2'b01, 2'b01, "fwd_inv");
    check("fwd_inv_hit",  64'(rspHit_o),  64'd0);
    check("fwd_inv_data", 64'(rspData_o), 64'h55);
    idle_inputs();

    // Flush with every requester valid.
    check("pre_flush_count", 64'(count_o), 64'd3);
    flush = 1'b1;
    wrVld = 2'b11; wrId[0] = 4'd9; wrId[1] = 4'd10;
    rdVld = 2'b11; rdId[0] = 4'd3; rdId[1] = 4'd5;
    run_cycle(2'b00, 2'b00, "flush");
    check("flush_count0", 64'(count_o), 64'd0);
    idle_inputs();
    rdVld = 2'b01; rdId[0] = 4'd7;
    run_cycle(2'b00, 2'b01, "post_flush_rd");
    check("post_flush_hit",  64'(rspHit_o),  64'd0);
    check("post_flush_data", 64'(rspData_o), 64'hDEADBEEF);
    idle_inputs();

    // Fill every entry, rewrite id 0, then invalidate id 10 twice.
    wrVld = 2'b01;
    for (int i = 0; i < 16; i++) begin
      wrId[0] = 4'(i); wrData[0] = $urandom;
      run_cycle(2'b01, 2'b00, "fill");
    end
    check("full_count", 64'(count_o), 64'd16);
    wrId[0] = 4'd0; wrData[0] = 32'hA5A5A5A5;
    run_cycle(2'b01, 2'b00, "rewrite0");
    check("full_sat", 64'(count_o), 64'd16);
    wrId[0] = 4'd10; wrInv = 2'b01;
    run_cycle(2'b01, 2'b00, "inv10_a");
    check("inv10_a_cnt", 64'(count_o), 64'd15);
    run_cycle(2'b01, 2'b00, "inv10_b");
    check("inv10_b_cnt", 64'(count_o), 64'd15);
    idle_inputs();

    // Random single-writer / single-reader traffic on a few ids.
    for (int n = 0; n < 24; n++) begin
      idle_inputs();
      wi = $urandom_range(0, 1);
      ri = $urandom_range(0, 1);
      ew = '0; er = '0;
      if ($urandom_range(0, 3) != 0) begin
        wrVld[wi]  = 1'b1;
        wrId[wi]   = 4'($urandom_range(0, 3));
        wrData[wi] = $urandom;
        wrInv[wi]  = ($urandom_range(0, 3) == 0);
        ew[wi]     = 1'b1;
      end
      if ($urandom_range(0, 3) != 0) begin
        rdVld[ri] = 1'b1;
        rdId[ri]  = 4'($urandom_range(0, 3));
        er[ri]    = 1'b1;
      end
      run_cycle(ew, er, "rand");
    end
    idle_inputs();
    run_cycle(2'b00, 2'b00, "idle2");

    // Reset asserted while a read is granted but not yet responded.
    rdVld = 2'b10; rdId[1] = 4'd1;
    #1;
    check("rst_rd_gnt", 64'(rdRdy_o), 64'b10);
    #1;
    rstn = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check("rst_now_count", 64'(count_o),  64'd0);
    check("rst_now_vld",   64'(rspVld_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_vld", 64'(rspVld_o), 64'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel_vld",   64'(rspVld_o),  64'd0);
    check("rst_rel_idx",   64'(rspIdx_o),  64'd0);
    check("rst_rel_hit",   64'(rspHit_o),  64'd0);
    check("rst_rel_data",  64'(rspData_o), 64'd0);
    check("rst_rel_count", 64'(count_o),   64'd0);

    // Pointer back at reader 0 after reset; data reads back as zero.
    rdVld = 2'b11; rdId[0] = 4'd0; rdId[1] = 4'd1;
    run_cycle(2'b00, 2'b01, "post_rst_c1");
    run_cycle(2'b00, 2'b10, "post_rst_c2");
    idle_inputs();

    for (int i = 0; i < 3; i++) run_cycle(2'b00, 2'b00, "drain");
    check("queue_drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
